gray_to_rgb_stream: RTL

//  Streaming grayscale-to-RGB colour mapper placed after the Sobel magnitude stage and before the display/VGA writer.

---
 rtl/sobel_pkg.sv | 15 +
 rtl/gray_scale_rep.sv | 17 +
 rtl/gray_to_rgb_stream.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel display path: colour-mapping modes and
// input-side framing FSM states.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_GRAY    = 2'b00,
    MODE_BINARY  = 2'b01,
    MODE_OVERLAY = 2'b10,
    MODE_INVERT  = 2'b11
  } mode_e;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/gray_scale_rep.sv
// Combinational IN_W -> OUT_W scaler: input is left-aligned and the low
// bits are filled by repeating the input MSBs (4'hA -> 8'hAA).
module gray_scale_rep #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  gray_i,
  output logic [OUT_W-1:0] scaled_o
);

  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    // Output bit i takes the input bit at the same distance from the MSB, modulo IN_W.
    localparam int SRC = IN_W - 1 - ((OUT_W - 1 - i) % IN_W);
    assign scaled_o[i] = gray_i[SRC];
  end

endmodule

// File: rtl/gray_to_rgb_stream.sv
// Streaming grayscale-to-RGB mapper with valid/ready backpressure and a 2-stage pipeline.
// Optional macro STATS_EN adds hit_cnt_o (per-frame count of above-threshold pixels).
//
//   state     | meaning
//   ST_IDLE   | between frames; cfg follows mode_i/thresh_i every cycle
//   ST_ACTIVE | inside a frame; cfg frozen until the eof beat is accepted
module gray_to_rgb_stream
  import sobel_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode_i,
  input  logic [IN_W-1:0]  thresh_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  gray_i,
  input  logic             sof_i,
  input  logic             eof_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] red_o,
  output logic [OUT_W-1:0] green_o,
  output logic [OUT_W-1:0] blue_o,
  output logic             eof_o,
  output logic             frame_done_o,
  output logic [CNT_W-1:0] pix_cnt_o,
  output logic             sof_err_o
`ifdef STATS_EN
  ,
  output logic [CNT_W-1:0] hit_cnt_o
`endif
);

  if (OUT_W < IN_W) begin : g_width_err
    $error("gray_to_rgb_stream: OUT_W must be >= IN_W");
  end
  if (IN_W < 1 || IN_W > 16) begin : g_in_w_err
    $error("gray_to_rgb_stream: IN_W must be in 1..16");
  end

  localparam logic [OUT_W-1:0] ONES    = {OUT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]      state_q, state_d;
  logic            sof_err_q, sof_err_d;
  logic [1:0]      cfg_mode_q;
  logic [IN_W-1:0] cfg_thresh_q;
  logic            is_idle;
  logic [1:0]      mode_eff;
  logic [IN_W-1:0] thresh_eff;

  logic            in_fire, out_fire, s2_adv;
  logic [OUT_W-1:0] g_scaled;

  logic             s1_valid_q;
  logic [OUT_W-1:0] s1_g_q;
  logic             s1_hit_q;
  logic [1:0]       s1_mode_q;
  logic             s1_eof_q;
  logic             s1_first_q;

  logic             s2_valid_q;
  logic [OUT_W-1:0] s2_red_q, s2_green_q, s2_blue_q;
  logic [OUT_W-1:0] red_d, green_d, blue_d;
  logic             s2_eof_q;
  logic             s2_first_q;

  logic             frame_done_q;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;

  // Handshake: S2 frees up when empty or draining, S1 when it can move into S2.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready_i;
    in_ready_o = !s1_valid_q || s2_adv;
    in_fire    = in_valid_i && in_ready_o;
    out_fire   = s2_valid_q && out_ready_i;
  end

  // In IDLE the live inputs apply, so the sof beat already uses the new settings.
  always_comb begin
    is_idle    = (state_q == ST_IDLE);
    mode_eff   = is_idle ? mode_i   : cfg_mode_q;
    thresh_eff = is_idle ? thresh_i : cfg_thresh_q;
  end

  always_comb begin
    state_d   = state_q;
    sof_err_d = sof_err_q;
    if (in_fire) begin
      case (state_q)
        ST_IDLE: begin
          if (!sof_i)      sof_err_d = 1'b1;
          else if (!eof_i) state_d   = ST_ACTIVE;
        end
        default: begin
          if (eof_i) state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sof_err_q    <= 1'b0;
      cfg_mode_q   <= '0;
      cfg_thresh_q <= '0;
    end else begin
      state_q   <= state_d;
      sof_err_q <= sof_err_d;
      if (is_idle) begin
        cfg_mode_q   <= mode_i;
        cfg_thresh_q <= thresh_i;
      end
    end
  end

  gray_scale_rep #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_scale (
    .gray_i   (gray_i),
    .scaled_o (g_scaled)
  );

  // S1: scaled pixel, threshold compare and the per-beat cfg travel together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_g_q     <= '0;
      s1_hit_q   <= 1'b0;
      s1_mode_q  <= '0;
      s1_eof_q   <= 1'b0;
      s1_first_q <= 1'b0;
    end else begin
      s1_valid_q <= in_fire || (s1_valid_q && !s2_adv);
      if (in_fire) begin
        s1_g_q     <= g_scaled;
        s1_hit_q   <= (gray_i >= thresh_eff);
        s1_mode_q  <= mode_eff;
        s1_eof_q   <= eof_i;
        s1_first_q <= is_idle;
      end
    end
  end

  always_comb begin
    red_d   = s1_g_q;
    green_d = s1_g_q;
    blue_d  = s1_g_q;
    case (s1_mode_q)
      MODE_GRAY: ;
      MODE_BINARY: begin
        red_d   = s1_hit_q ? ONES : '0;
        green_d = s1_hit_q ? ONES : '0;
        blue_d  = s1_hit_q ? ONES : '0;
      end
      MODE_OVERLAY: begin
        if (s1_hit_q) begin
          red_d   = ONES;
          green_d = '0;
          blue_d  = '0;
        end
      end
      default: begin
        red_d   = ~s1_g_q;
        green_d = ~s1_g_q;
        blue_d  = ~s1_g_q;
      end
    endcase
  end

  // S2: output registers, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_red_q   <= '0;
      s2_green_q <= '0;
      s2_blue_q  <= '0;
      s2_eof_q   <= 1'b0;
      s2_first_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_red_q   <= red_d;
        s2_green_q <= green_d;
        s2_blue_q  <= blue_d;
        s2_eof_q   <= s1_eof_q;
        s2_first_q <= s1_first_q;
      end
    end
  end

  // A beat accepted in IDLE opens a new frame and restarts the count at 1.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (out_fire) begin
      if (s2_first_q)                pix_cnt_d = CNT_W'(1);
      else if (pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= out_fire && s2_eof_q;
    end
  end

`ifdef STATS_EN
  logic             s2_hit_q;
  logic [CNT_W-1:0] run_q, run_base, run_next, hit_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       s2_hit_q <= 1'b0;
    else if (s2_adv && s1_valid_q)    s2_hit_q <= s1_hit_q;
  end

  always_comb begin
    run_base = s2_first_q ? '0 : run_q;
    run_next = run_base;
    if (s2_hit_q && run_base != CNT_MAX) run_next = run_base + CNT_W'(1);
  end

  // Published on the eof transfer, so it changes together with frame_done_o rising.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= '0;
      hit_cnt_q <= '0;
    end else if (out_fire) begin
      if (s2_eof_q) begin
        hit_cnt_q <= run_next;
        run_q     <= '0;
      end else begin
        run_q <= run_next;
      end
    end
  end

  assign hit_cnt_o = hit_cnt_q;
`endif

  assign out_valid_o  = s2_valid_q;
  assign red_o        = s2_red_q;
  assign green_o      = s2_green_q;
  assign blue_o       = s2_blue_q;
  assign eof_o        = s2_eof_q;
  assign frame_done_o = frame_done_q;
  assign pix_cnt_o    = pix_cnt_q;
  assign sof_err_o    = sof_err_q;

endmodule
